// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the digit-serial ALU: opcode encodings,
//            FSM state type and the operand-B inversion helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Subtraction-based opcodes add the one's complement of B plus an
  // initial carry of 1.
  function automatic logic op_inv(input logic [2:0] sel);
    return (sel == OP_SUB) || (sel == OP_SLT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_alu.sv
// ============================================================================
// Module   : digit_alu
// Purpose  : Combinational DIGIT-bit ALU slice used once per cycle by the
//            serial ALU.
// Ports    : a_d, b_d  - operand digits
//            cin       - carry into the digit's LSB
//            sel       - opcode
//            sum_d     - digit result (zero for illegal opcodes)
//            cout_d    - carry out of the digit's top bit
//            c_msb_d   - carry into the digit's top bit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_alu
  import alu_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  input  logic [2:0]       sel,
  output logic [DIGIT-1:0] sum_d,
  output logic             cout_d,
  output logic             c_msb_d
);

  logic             inv;
  logic [DIGIT-1:0] b_x;
  logic [DIGIT:0]   add;

  assign inv = op_inv(sel);
  assign b_x = b_d ^ {DIGIT{inv}};
  assign add = {1'b0, a_d} + {1'b0, b_x} + {{DIGIT{1'b0}}, cin};

  assign cout_d = add[DIGIT];
  // Sum bit = a ^ b ^ carry-in, so the carry into the top bit is recovered
  // by XORing the operands back out of the sum.
  assign c_msb_d = add[DIGIT-1] ^ a_d[DIGIT-1] ^ b_x[DIGIT-1];

  always_comb begin
    sum_d = '0;
    case (sel)
      OP_AND:                 sum_d = a_d & b_d;
      OP_OR:                  sum_d = a_d | b_d;
      OP_ADD, OP_SUB, OP_SLT: sum_d = add[DIGIT-1:0];
      default:                sum_d = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/serial_alu.sv
// ============================================================================
// Module   : serial_alu
// Purpose  : Digit-serial integer ALU. Processes a WIDTH-bit operation DIGIT
//            bits per cycle, LSB digit first, with valid/ready handshakes on
//            both the request and result sides.
// Ports    : clk, rst_n           - clock, async active-low reset
//            in_valid, in_ready   - request handshake
//            a, b, sel            - operands and opcode (sampled on accept)
//            out_valid, out_ready - result handshake
//            result, cout,
//            overflow, zero       - result and status flags (held in DONE)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  logic [DIGIT-1:0] sum_d;
  logic             cout_d;
  logic             c_msb_d;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] res_final;
  logic             last;
  logic             arith;
  logic             accept;
  logic             ovf_d;

  // Operands are shifted right each cycle so the active digit always sits
  // in the low DIGIT bits; this avoids a wide variable-index mux.
  digit_alu #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a_d     (a_q[DIGIT-1:0]),
    .b_d     (b_q[DIGIT-1:0]),
    .cin     (carry),
    .sel     (sel_q),
    .sum_d   (sum_d),
    .cout_d  (cout_d),
    .c_msb_d (c_msb_d)
  );

  generate
    if (WIDTH > DIGIT) begin : g_multi_digit
      assign a_shift   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
      assign b_shift   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
      // Result digits enter at the MSB end; after N digits the first one
      // has reached bit 0.
      assign res_shift = {sum_d, result[WIDTH-1:DIGIT]};
    end else begin : g_single_digit
      assign a_shift   = '0;
      assign b_shift   = '0;
      assign res_shift = sum_d;
    end
  endgenerate

  assign last   = (cnt == CNT_W'(N - 1));
  assign arith  = (sel_q == OP_ADD) || (sel_q == OP_SUB) || (sel_q == OP_SLT);
  assign accept = (state == IDLE) && in_valid;
  assign ovf_d  = c_msb_d ^ cout_d;

  // SLT: a < b (signed) exactly when sign(a-b) differs from the overflow.
  always_comb begin
    res_final = res_shift;
    if (sel_q == OP_SLT) begin
      res_final    = '0;
      res_final[0] = sum_d[DIGIT-1] ^ ovf_d;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sel_q <= sel;
      cnt   <= '0;
      carry <= op_inv(sel);
    end else if (state == RUN) begin
      a_q   <= a_shift;
      b_q   <= b_shift;
      carry <= cout_d;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        result   <= res_final;
        cout     <= arith & cout_d;
        overflow <= arith & ovf_d;
        zero     <= (res_final == '0);
      end else begin
        result <= res_shift;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_alu.sv
// ============================================================================
// Module   : tb_serial_alu
// Purpose  : Self-checking bench for serial_alu at three configurations
//            (32/4, 8/8, 16/1) against an arithmetic reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic [2:0]  sv [3];
  logic [2:0]  irdy;
  logic [2:0]  ovld;
  logic [2:0]  co;
  logic [2:0]  of;
  logic [2:0]  zf;
  logic [31:0] r0;
  logic [7:0]  r1;
  logic [15:0] r2;
  logic [31:0] res [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    res[0] = r0;
    res[1] = {24'b0, r1};
    res[2] = {16'b0, r2};
  end

  serial_alu #(.WIDTH(32), .DIGIT(4)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(av[0]), .b(bv[0]), .sel(sv[0]), .out_valid(ovld[0]),
    .out_ready(ordy[0]), .result(r0), .cout(co[0]), .overflow(of[0]), .zero(zf[0])
  );

  serial_alu #(.WIDTH(8), .DIGIT(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(av[1][7:0]), .b(bv[1][7:0]), .sel(sv[1]), .out_valid(ovld[1]),
    .out_ready(ordy[1]), .result(r1), .cout(co[1]), .overflow(of[1]), .zero(zf[1])
  );

  serial_alu #(.WIDTH(16), .DIGIT(1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(av[2][15:0]), .b(bv[2][15:0]), .sel(sv[2]), .out_valid(ovld[2]),
    .out_ready(ordy[2]), .result(r2), .cout(co[2]), .overflow(of[2]), .zero(zf[2])
  );

  function automatic int wid(input int i);
    return (i == 0) ? 32 : (i == 1) ? 8 : 16;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 8 : (i == 1) ? 1 : 16;
  endfunction

  // Reference: {result[31:0], cout, overflow, zero} from w-bit arithmetic.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] s, input int w);
    longint unsigned m, aa, bb, sum, diff;
    longint          sa_v, sb_v;
    logic [31:0]     r;
    logic            c, o, sa, sb, sr;
    m  = (64'd1 << w) - 1;
    aa = {32'b0, a} & m;
    bb = {32'b0, b} & m;
    sa = 1'((aa >> (w - 1)) & 1);
    sb = 1'((bb >> (w - 1)) & 1);
    r  = '0;
    c  = 1'b0;
    o  = 1'b0;
    case (s)
      3'b000: r = 32'(aa & bb);
      3'b001: r = 32'(aa | bb);
      3'b010: begin
        sum = aa + bb;
        c   = 1'((sum >> w) & 1);
        r   = 32'(sum & m);
        sr  = 1'((sum >> (w - 1)) & 1);
        o   = (sa == sb) && (sr != sa);
      end
      3'b110, 3'b111: begin
        sum  = aa + ((~bb) & m) + 1;
        c    = 1'((sum >> w) & 1);
        diff = sum & m;
        sr   = 1'((diff >> (w - 1)) & 1);
        o    = (sa != sb) && (sr != sa);
        if (s == 3'b110) begin
          r = 32'(diff);
        end else begin
          sa_v = sa ? longint'(aa) - longint'(64'd1 << w) : longint'(aa);
          sb_v = sb ? longint'(bb) - longint'(64'd1 << w) : longint'(bb);
          r    = (sa_v < sb_v) ? 32'd1 : 32'd0;
        end
      end
      default: r = '0;
    endcase
    return {r, c, o, (r == 32'd0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] s, input int hold);
    logic [34:0] e;
    logic [31:0] held;
    int          n;
    e = model(a, b, s, wid(i));
    chk("in_ready_idle", {31'b0, irdy[i]}, 32'd1);
    iv[i] = 1'b1;
    av[i] = a;
    bv[i] = b;
    sv[i] = s;
    @(posedge clk); #1;
    iv[i] = 1'b0;
    av[i] = $urandom;
    bv[i] = $urandom;
    sv[i] = 3'($urandom);
    chk("in_ready_run", {31'b0, irdy[i]}, 32'd0);
    n = 0;
    while (!ovld[i] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat(i)));
    chk("result", res[i], e[34:3]);
    chk("cout", {31'b0, co[i]}, {31'b0, e[2]});
    chk("overflow", {31'b0, of[i]}, {31'b0, e[1]});
    chk("zero", {31'b0, zf[i]}, {31'b0, e[0]});
    held = res[i];
    for (int h = 0; h < hold; h++) begin
      iv[i] = 1'b1;
      av[i] = $urandom;
      @(posedge clk); #1;
      chk("bp_out_valid", {31'b0, ovld[i]}, 32'd1);
      chk("bp_in_ready", {31'b0, irdy[i]}, 32'd0);
      chk("bp_result", res[i], held);
    end
    ordy[i] = 1'b1;
    @(posedge clk); #1;
    ordy[i] = 1'b0;
    iv[i]   = 1'b0;
    chk("release_out_valid", {31'b0, ovld[i]}, 32'd0);
    chk("release_in_ready", {31'b0, irdy[i]}, 32'd1);
    chk("release_result", res[i], held);
  endtask

  initial begin
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '0;
    for (int i = 0; i < 3; i++) begin
      av[i] = '0;
      bv[i] = '0;
      sv[i] = '0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_result", res[i], 32'd0);
      chk("rst_flags", {28'b0, co[i], of[i], zf[i], ovld[i]}, 32'd0);
      chk("rst_in_ready", {31'b0, irdy[i]}, 32'd1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      do_op(i, 32'h7FFFFFFF, 32'h00000001, 3'b010, 0);
      do_op(i, 32'h00000005, 32'h00000005, 3'b110, 0);
      do_op(i, 32'h00000000, 32'h00000001, 3'b110, 0);
      do_op(i, 32'hFFFFFFFF, 32'h00000001, 3'b111, 0);
      do_op(i, 32'h80000000, 32'h00000001, 3'b111, 0);
      do_op(i, 32'h00000005, 32'h00000003, 3'b111, 0);
      do_op(i, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 0);
      do_op(i, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 3);
      do_op(i, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b100, 0);
      do_op(i, 32'h12345678, 32'h9ABCDEF0, 3'b011, 1);
      do_op(i, 32'h12345678, 32'h9ABCDEF0, 3'b101, 0);
      // The narrow configurations see the MSB-oriented vectors truncated,
      // so their own sign-boundary cases are exercised explicitly.
      do_op(i, 32'h00007FFF, 32'h00000001, 3'b010, 0);
      do_op(i, 32'h0000007F, 32'h00000001, 3'b010, 0);
      do_op(i, 32'h00000080, 32'h00000001, 3'b111, 0);
      do_op(i, 32'h00008000, 32'h00000001, 3'b111, 0);
    end

    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 25; k++) begin
        do_op(i, $urandom, $urandom, 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end
    end

    // Reset during an operation, then confirm normal service resumes.
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b1;
      av[i] = 32'hDEADBEEF;
      bv[i] = 32'h01234567;
      sv[i] = 3'b010;
      @(posedge clk); #1;
      iv[i] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_result", res[i], 32'd0);
      chk("midrst_flags", {28'b0, co[i], of[i], zf[i], ovld[i]}, 32'd0);
      chk("midrst_in_ready", {31'b0, irdy[i]}, 32'd1);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(i, 32'd2, 32'd3, 3'b010, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
